// File: rtl/board_io_ctrl.sv
// Board I/O front-end: switch synchronise/debounce, stretched cpu reset
// sequencer, and registered LED outputs with a switch-loopback mode.
module board_io_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic                 rst_req,
  input  logic                 led_sel,
  input  logic [LED_WIDTH-1:0] cpu_led,
  output logic [SW_WIDTH-1:0]  sw_out,
  output logic                 sw_event,
  output logic                 cpu_rst,
  output logic [LED_WIDTH-1:0] led_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES - 1);

  typedef enum logic {HOLD, RUN} state_t;

  logic [SW_WIDTH-1:0]  sync1, sync2, upd;
  logic [CW-1:0]        cnt [SW_WIDTH];
  logic [LED_WIDTH-1:0] sw_led;
  logic [HW-1:0]        hold_cnt, hold_nxt;
  state_t               state, state_nxt;

  // A channel flips only after its mismatch has persisted DEBOUNCE_CYCLES edges
  always_comb begin
    upd = '0;
    for (int i = 0; i < SW_WIDTH; i++)
      upd[i] = (sync2[i] != sw_out[i]) && (cnt[i] == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sw_out   <= '0;
      sw_event <= 1'b0;
      for (int i = 0; i < SW_WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1    <= sw_in;
      sync2    <= sync1;
      sw_out   <= (sw_out & ~upd) | (sync2 & upd);
      sw_event <= |upd;
      for (int i = 0; i < SW_WIDTH; i++) begin
        if ((sync2[i] == sw_out[i]) || upd[i]) cnt[i] <= '0;
        else                                   cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HOLD;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // A request during HOLD restarts the window, taking priority over expiry
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      HOLD: begin
        if (rst_req) begin
          hold_nxt = '0;
        end else if (hold_cnt == HOLD_MAX) begin
          state_nxt = RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      RUN: begin
        if (rst_req) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = HOLD;
        hold_nxt  = '0;
      end
    endcase
  end

  assign cpu_rst = (state == HOLD);

  generate
    if (SW_WIDTH >= LED_WIDTH) begin : g_trunc
      assign sw_led = sw_out[LED_WIDTH-1:0];
    end else begin : g_zext
      assign sw_led = {{(LED_WIDTH - SW_WIDTH){1'b0}}, sw_out};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          led_out <= '0;
    else if (cpu_rst) led_out <= '0;
    else if (led_sel) led_out <= sw_led;
    else              led_out <= cpu_led;
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8.
module tb_board_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_in;
  logic        rst_req;
  logic        led_sel;
  logic [15:0] cpu_led;
  logic [15:0] sw_out;
  logic        sw_event;
  logic        cpu_rst;
  logic [15:0] led_out;

  int checks = 0;
  int errors = 0;

  board_io_ctrl #(
    .SW_WIDTH(16), .LED_WIDTH(16), .DEBOUNCE_CYCLES(4), .RST_HOLD_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .rst_req(rst_req), .led_sel(led_sel),
    .cpu_led(cpu_led), .sw_out(sw_out), .sw_event(sw_event), .cpu_rst(cpu_rst),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw_in = 16'h0000; rst_req = 1'b0; led_sel = 1'b0; cpu_led = 16'h5A5A;

    // 1: reset and hold release
    repeat (3) tick();
    chk("rst_sw_out", 32'(sw_out), 32'h0);
    chk("rst_sw_event", 32'(sw_event), 32'h0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("rst_led_out", 32'(led_out), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("hold_cpu_rst_e%0d", k), 32'(cpu_rst), 32'h1);
      chk($sformatf("hold_led_e%0d", k), 32'(led_out), 32'h0);
    end
    tick();
    chk("release_cpu_rst_e8", 32'(cpu_rst), 32'h0);
    chk("release_led_e8", 32'(led_out), 32'h0);
    tick();
    chk("run_led_cpu", 32'(led_out), 32'h5A5A);

    // 2: debounce latency
    sw_in = 16'h00A5;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("deb_sw_out_e%0d", k), 32'(sw_out), 32'h0);
      chk($sformatf("deb_event_e%0d", k), 32'(sw_event), 32'h0);
    end
    tick();
    chk("deb_sw_out_e6", 32'(sw_out), 32'h00A5);
    chk("deb_event_e6", 32'(sw_event), 32'h1);
    tick();
    chk("deb_event_e7", 32'(sw_event), 32'h0);

    // 3: 3-cycle glitch rejected
    sw_in = 16'h00AD;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) sw_in = 16'h00A5;
      chk($sformatf("glitch_sw_out_e%0d", k), 32'(sw_out), 32'h00A5);
      chk($sformatf("glitch_event_e%0d", k), 32'(sw_event), 32'h0);
    end
    // 3: 4-cycle pulse accepted, then released again
    sw_in = 16'h00AD;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) sw_in = 16'h00A5;
      chk($sformatf("pulse_sw_out_e%0d", k), 32'(sw_out),
          (k >= 6 && k <= 9) ? 32'h00AD : 32'h00A5);
      chk($sformatf("pulse_event_e%0d", k), 32'(sw_event),
          (k == 6 || k == 10) ? 32'h1 : 32'h0);
    end

    // 5: LED path
    cpu_led = 16'hBEEF;
    tick();
    chk("led_cpu_beef", 32'(led_out), 32'hBEEF);
    sw_in = 16'h1234;
    repeat (6) tick();
    chk("led_sw_ready", 32'(sw_out), 32'h1234);
    chk("led_still_cpu", 32'(led_out), 32'hBEEF);
    led_sel = 1'b1;
    tick();
    chk("led_loopback", 32'(led_out), 32'h1234);
    led_sel = 1'b0;
    tick();
    chk("led_back_cpu", 32'(led_out), 32'hBEEF);

    // 4: soft reset request
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    chk("req_cpu_rst_e0", 32'(cpu_rst), 32'h1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("req_hold_e%0d", k), 32'(cpu_rst), 32'h1);
    end
    chk("req_led_zero", 32'(led_out), 32'h0);
    tick();
    chk("req_release_e8", 32'(cpu_rst), 32'h0);
    // 4: second request at hold edge 5 extends the window
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k == 5) rst_req = 1'b1;
      tick();
      rst_req = 1'b0;
      chk($sformatf("ext_cpu_rst_e%0d", k), 32'(cpu_rst), (k == 13) ? 32'h0 : 32'h1);
    end

    // 6: async reset mid-debounce and mid-hold
    rst_req = 1'b1;
    sw_in = 16'h0001;
    tick();
    rst_req = 1'b0;
    repeat (3) tick();
    chk("mid_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("mid_sw_out", 32'(sw_out), 32'h1234);
    rst = 1'b1;
    #1;
    chk("async_sw_out", 32'(sw_out), 32'h0);
    chk("async_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("async_led", 32'(led_out), 32'h0);
    chk("async_event", 32'(sw_event), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("post_sw_out_e%0d", k), 32'(sw_out), (k >= 6) ? 32'h0001 : 32'h0);
      chk($sformatf("post_cpu_rst_e%0d", k), 32'(cpu_rst), (k == 8) ? 32'h0 : 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
